bscan_shift_port: RTL and testbench
===================================

// Module: bscan_shift_port
// PURPOSE
// JTAG-side data-register engine for a BSCAN user chain. It turns the
// asynchronous BSCAN primitive strobes (TCK/TDI/SEL/CAPTURE/SHIFT/UPDATE)
// into a WIDTH+1-bit scan register, sampled entirely in the CLK domain.
// It is the chain end of the pipe pair a host test block uses: it accepts
// words to send to the JTAG host (to_*) and emits words the host wrote (from_*).
// PARAMETERS
// WIDTH        32  payload bits per scan word
// SYNC_STAGES   2  synchroniser depth for the JTAG inputs (>=2)
// PORTS
// CLK            in   1      system clock; must be >= 4x TCK
// nRST           in   1      synchronous reset, active-low
// jtag_tck       in   1      BSCAN TCK, async
// jtag_tdi       in   1      BSCAN TDI, async
// jtag_sel       in   1      BSCAN SEL (this user chain selected), async
// jtag_capture   in   1      BSCAN CAPTURE, async
// jtag_shift     in   1      BSCAN SHIFT, async
// jtag_update    in   1      BSCAN UPDATE, async
// jtag_tdo       out  1      scan-out to BSCAN TDO
// to_enq__ENA    in   1      word offered toward host
// to_enq_v       in   WIDTH  offered word
// to_enq__RDY    out  1      tx holding register empty
// from_enq__ENA  out  1      word from host valid
// from_enq_v     out  WIDTH  word from host
// from_enq__RDY  in   1      consumer accepts
// overflow_count out  8      host words dropped, saturating
// rx_count       out  8      host words delivered, wraps 255->0
// BEHAVIOUR
// - Reset values: jtag_tdo=0, to_enq__RDY=1 (tx empty), from_enq__ENA=0,
//   from_enq_v=0, overflow_count=0, rx_count=0, scan register sr=0.
//   All sync flops=0. Reset mid-scan abandons the scan. No words are delivered.
// - Sync: each jtag_* input goes through a SYNC_STAGES flop chain.
//   tck_rise is a 1-cycle pulse when synced TCK goes 0->1, and acts in the
//   next cycle. upd_rise is the same for synced UPDATE.
// - Capture: tck_rise & sel & capture -> sr <= {tx_data, tx_full}.
//   This sets sr[0] to the valid flag and sr[WIDTH:1] to the data, then clears tx_full.
// - Shift: tck_rise & sel & shift & !capture -> sr <= {tdi, sr[WIDTH:1]}.
//   Input enters at the MSB and the LSB leaves first.
// - jtag_tdo is registered and always follows sr[0]. It settles within 1 CLK
//   of each shift, well before the next TCK rise.
// - Update: upd_rise & sel. If sr[0]==1, sr[WIDTH:1] is the host word;
//   if sr[0]==0 the update is ignored.
// - Tx: to_enq__RDY = !tx_full. An accept loads tx_data and sets tx_full.
//   An accept in the same cycle as capture: capture takes the old state
//   (flag 0), and the new word is held for the next capture.
// - Rx: 1-entry buffer. from_enq__ENA = rx_full, from_enq_v = rx_data.
//   A pop (ENA & RDY) clears rx_full and increments rx_count.
//   Valid update with rx_full=0, or rx_full=1 with a pop in the same cycle
//   -> load the new word and set rx_full.
//   Valid update with rx_full=1 and no pop -> drop the new word, keep the old,
//   overflow_count++ (saturates at 255).
// - SEL=0 blocks all capture, shift and update actions. TCK edges are still tracked.
// - Latency: at most SYNC_STAGES+2 CLK from a TCK/UPDATE pin edge to the
//   register effect.
// TESTING
// 1. Reset then idle -> to_enq__RDY=1, from_enq__ENA=0, jtag_tdo=0, counters 0.
// 2. Enq 0xA5A5_0F0F, then host scan of 33 bits -> TDO stream 1, then
//    0xA5A5_0F0F LSB-first; to_enq__RDY returns to 1 after the capture.
// 3. Capture with tx empty -> first TDO bit 0. Enq in the capture cycle ->
//    the word appears on the next scan.
// 4. Host shifts flag=1 with data 0x1234_5678, then update -> from_enq_v=0x1234_5678,
//    ENA=1. Pop -> rx_count=1. Flag=0 scan -> no ENA.
// 5. from_enq__RDY=0 with 3 valid updates -> first word held, overflow_count=2.
//    Update coincident with a pop -> new word loaded, no overflow.
// 6. nRST asserted mid-shift (after 10 bits), then a full scan -> first scan
//    after reset behaves as in case 3. SEL=0 scans -> sr and TDO unchanged.

Source files
------------

// File: rtl/bscan_shift_port_if.sv
// rtl/bscan_shift_port_if.sv - word pipe pair between the scan port and the host test block
interface bscan_shift_port_if #(
    parameter int WIDTH = 32
);
    logic             to_enq__ENA;
    logic [WIDTH-1:0] to_enq_v;
    logic             to_enq__RDY;
    logic             from_enq__ENA;
    logic [WIDTH-1:0] from_enq_v;
    logic             from_enq__RDY;

    modport master (
        output to_enq__ENA, to_enq_v, from_enq__RDY,
        input  to_enq__RDY, from_enq__ENA, from_enq_v
    );

    modport slave (
        input  to_enq__ENA, to_enq_v, from_enq__RDY,
        output to_enq__RDY, from_enq__ENA, from_enq_v
    );
endinterface

// File: rtl/bscan_shift_port.sv
// rtl/bscan_shift_port.sv - BSCAN user-chain data register sampled in the CLK domain
module bscan_shift_port #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  jtag_tck,
    input  logic                  jtag_tdi,
    input  logic                  jtag_sel,
    input  logic                  jtag_capture,
    input  logic                  jtag_shift,
    input  logic                  jtag_update,
    output logic                  jtag_tdo,
    bscan_shift_port_if.slave     pipe,
    output logic [7:0]            overflow_count,
    output logic [7:0]            rx_count
);
    logic [SYNC_STAGES-1:0] tck_q, tdi_q, sel_q, cap_q, sh_q, upd_q;
    logic                   tck_d, upd_d;
    logic [WIDTH:0]         sr;
    logic [WIDTH-1:0]       tx_data, rx_data;
    logic                   tx_full, rx_full;

    logic tck_s, tdi_s, sel_s, cap_s, sh_s, upd_s;
    logic tck_rise, upd_rise;
    logic do_capture, do_shift, do_update;
    logic accept, pop;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            tck_q <= '0;
            tdi_q <= '0;
            sel_q <= '0;
            cap_q <= '0;
            sh_q  <= '0;
            upd_q <= '0;
            tck_d <= 1'b0;
            upd_d <= 1'b0;
        end else begin
            tck_q <= {tck_q[SYNC_STAGES-2:0], jtag_tck};
            tdi_q <= {tdi_q[SYNC_STAGES-2:0], jtag_tdi};
            sel_q <= {sel_q[SYNC_STAGES-2:0], jtag_sel};
            cap_q <= {cap_q[SYNC_STAGES-2:0], jtag_capture};
            sh_q  <= {sh_q[SYNC_STAGES-2:0], jtag_shift};
            upd_q <= {upd_q[SYNC_STAGES-2:0], jtag_update};
            tck_d <= tck_s;
            upd_d <= upd_s;
        end
    end

    assign tck_s = tck_q[SYNC_STAGES-1];
    assign tdi_s = tdi_q[SYNC_STAGES-1];
    assign sel_s = sel_q[SYNC_STAGES-1];
    assign cap_s = cap_q[SYNC_STAGES-1];
    assign sh_s  = sh_q[SYNC_STAGES-1];
    assign upd_s = upd_q[SYNC_STAGES-1];

    // Edges are tracked even while deselected so reselecting never sees a stale edge.
    assign tck_rise   = tck_s & ~tck_d;
    assign upd_rise   = upd_s & ~upd_d;
    assign do_capture = tck_rise & sel_s & cap_s;
    assign do_shift   = tck_rise & sel_s & sh_s & ~cap_s;
    assign do_update  = upd_rise & sel_s & sr[0];

    assign accept = pipe.to_enq__ENA & ~tx_full;
    assign pop    = rx_full & pipe.from_enq__RDY;

    assign pipe.to_enq__RDY   = ~tx_full;
    assign pipe.from_enq__ENA = rx_full;
    assign pipe.from_enq_v    = rx_data;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sr       <= '0;
            jtag_tdo <= 1'b0;
        end else begin
            if (do_capture)
                sr <= {tx_data, tx_full};
            else if (do_shift)
                sr <= {tdi_s, sr[WIDTH:1]};
            jtag_tdo <= sr[0];
        end
    end

    // A word accepted in the capture cycle is not captured; it waits for the next scan.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            tx_data <= '0;
            tx_full <= 1'b0;
        end else if (accept) begin
            tx_data <= pipe.to_enq_v;
            tx_full <= 1'b1;
        end else if (do_capture) begin
            tx_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rx_data        <= '0;
            rx_full        <= 1'b0;
            rx_count       <= '0;
            overflow_count <= '0;
        end else begin
            if (pop)
                rx_count <= rx_count + 8'd1;
            if (do_update && (!rx_full || pop)) begin
                rx_data <= sr[WIDTH:1];
                rx_full <= 1'b1;
            end else if (do_update) begin
                if (overflow_count != 8'hFF)
                    overflow_count <= overflow_count + 8'd1;
            end else if (pop) begin
                rx_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bscan_shift_port.sv
// tb/tb_bscan_shift_port.sv - scoreboard bench for bscan_shift_port
module tb_bscan_shift_port;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic jtag_tck = 1'b0, jtag_tdi = 1'b0, jtag_sel = 1'b0;
    logic jtag_capture = 1'b0, jtag_shift = 1'b0, jtag_update = 1'b0;
    logic jtag_tdo;
    logic [7:0] overflow_count, rx_count;

    bscan_shift_port_if #(.WIDTH(W)) pipe ();

    bscan_shift_port #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi), .jtag_sel(jtag_sel),
        .jtag_capture(jtag_capture), .jtag_shift(jtag_shift), .jtag_update(jtag_update),
        .jtag_tdo(jtag_tdo), .pipe(pipe),
        .overflow_count(overflow_count), .rx_count(rx_count)
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_word;
    logic [W:0]   dout;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen here is the one the DUT takes on the next rising edge.
    always @(negedge CLK) begin
        #1;
        if (nRST && pipe.from_enq__ENA && pipe.from_enq__RDY) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rx_unexpected: got %h expected no word", pipe.from_enq_v);
            end else begin
                exp_word = exp_q.pop_front();
                check("rx_word", {32'h0, pipe.from_enq_v}, {32'h0, exp_word});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic enq(input logic [W-1:0] w);
        int n = 0;
        @(negedge CLK);
        while (!pipe.to_enq__RDY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("enq_rdy_wait", {63'h0, pipe.to_enq__RDY}, 64'h1);
        pipe.to_enq__ENA = 1'b1;
        pipe.to_enq_v    = w;
        @(negedge CLK);
        pipe.to_enq__ENA = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge CLK);
        pipe.from_enq__RDY = 1'b1;
        @(negedge CLK);
        pipe.from_enq__RDY = 1'b0;
    endtask

    // One DR scan: capture, WIDTH+1 shifts (TDO read before each rising TCK), update.
    task automatic scan(input logic [W:0] din, input logic sel, input logic enq_cap,
                        input logic [W-1:0] enq_word, input logic pop_upd,
                        output logic [W:0] got);
        @(negedge CLK);
        jtag_sel = sel;
        jtag_capture = 1'b1;
        jtag_tck = 1'b0;
        #60;
        jtag_tck = 1'b1;
        if (enq_cap) begin
            pipe.to_enq_v = enq_word;
            fork
                begin
                    #20 pipe.to_enq__ENA = 1'b1;
                    #10 pipe.to_enq__ENA = 1'b0;
                end
            join_none
        end
        #60;
        jtag_capture = 1'b0;
        jtag_shift = 1'b1;
        for (int i = 0; i <= W; i++) begin
            jtag_tck = 1'b0;
            jtag_tdi = din[i];
            #60;
            got[i] = jtag_tdo;
            jtag_tck = 1'b1;
            #60;
        end
        jtag_tck = 1'b0;
        jtag_shift = 1'b0;
        #60;
        jtag_update = 1'b1;
        if (pop_upd) begin
            fork
                begin
                    #20 pipe.from_enq__RDY = 1'b1;
                    #10 pipe.from_enq__RDY = 1'b0;
                end
            join_none
        end
        #60;
        jtag_update = 1'b0;
        #60;
        jtag_sel = 1'b0;
    endtask

    initial begin
        pipe.to_enq__ENA = 1'b0;
        pipe.to_enq_v = '0;
        pipe.from_enq__RDY = 1'b0;
        repeat (4) @(negedge CLK);
        nRST = 1'b1;
        repeat (4) @(negedge CLK);

        // 1. reset state
        check("rst_to_rdy", {63'h0, pipe.to_enq__RDY}, 64'h1);
        check("rst_from_ena", {63'h0, pipe.from_enq__ENA}, 64'h0);
        check("rst_from_v", {32'h0, pipe.from_enq_v}, 64'h0);
        check("rst_tdo", {63'h0, jtag_tdo}, 64'h0);
        check("rst_ovf", {56'h0, overflow_count}, 64'h0);
        check("rst_rxc", {56'h0, rx_count}, 64'h0);

        // 2. word toward host comes out flag-first then LSB-first
        enq(32'hA5A5_0F0F);
        check("tx_full_rdy", {63'h0, pipe.to_enq__RDY}, 64'h0);
        scan(33'h0, 1'b1, 1'b0, '0, 1'b0, dout);
        check("tx_scan", {31'h0, dout}, {31'h0, 32'hA5A5_0F0F, 1'b1});
        check("tx_rdy_after", {63'h0, pipe.to_enq__RDY}, 64'h1);
        check("flag0_no_ena", {63'h0, pipe.from_enq__ENA}, 64'h0);

        // 3. empty capture, enqueue coincident with capture
        scan(33'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, dout);
        check("empty_flag", {63'h0, dout[0]}, 64'h0);
        check("held_rdy", {63'h0, pipe.to_enq__RDY}, 64'h0);
        scan(33'h0, 1'b1, 1'b0, '0, 1'b0, dout);
        check("held_scan", {31'h0, dout}, {31'h0, 32'hDEAD_BEEF, 1'b1});

        // 4. host word delivered, popped; flag 0 ignored
        exp_q.push_back(32'h1234_5678);
        scan({32'h1234_5678, 1'b1}, 1'b1, 1'b0, '0, 1'b0, dout);
        check("rx_ena", {63'h0, pipe.from_enq__ENA}, 64'h1);
        check("rx_v", {32'h0, pipe.from_enq_v}, {32'h0, 32'h1234_5678});
        pop_one();
        check("rx_count1", {56'h0, rx_count}, 64'h1);
        check("rx_ena_clr", {63'h0, pipe.from_enq__ENA}, 64'h0);
        scan({32'hFFFF_FFFF, 1'b0}, 1'b1, 1'b0, '0, 1'b0, dout);
        check("flag0_ignored", {63'h0, pipe.from_enq__ENA}, 64'h0);

        // 5. overflow with consumer stalled, then update coincident with pop
        exp_q.push_back(32'h1111_1111);
        scan({32'h1111_1111, 1'b1}, 1'b1, 1'b0, '0, 1'b0, dout);
        scan({32'h2222_2222, 1'b1}, 1'b1, 1'b0, '0, 1'b0, dout);
        scan({32'h3333_3333, 1'b1}, 1'b1, 1'b0, '0, 1'b0, dout);
        check("ovf_2", {56'h0, overflow_count}, 64'h2);
        check("ovf_held", {32'h0, pipe.from_enq_v}, {32'h0, 32'h1111_1111});
        exp_q.push_back(32'h4444_4444);
        scan({32'h4444_4444, 1'b1}, 1'b1, 1'b0, '0, 1'b1, dout);
        check("coinc_ovf", {56'h0, overflow_count}, 64'h2);
        check("coinc_ena", {63'h0, pipe.from_enq__ENA}, 64'h1);
        check("coinc_v", {32'h0, pipe.from_enq_v}, {32'h0, 32'h4444_4444});
        pop_one();
        check("rx_count3", {56'h0, rx_count}, 64'h3);

        // 6. reset mid-shift after 10 bits
        enq(32'h5A5A_5A5A);
        @(negedge CLK);
        jtag_sel = 1'b1;
        jtag_capture = 1'b1;
        #60 jtag_tck = 1'b1;
        #60 jtag_capture = 1'b0;
        jtag_shift = 1'b1;
        repeat (10) begin
            jtag_tck = 1'b0;
            jtag_tdi = 1'b1;
            #60 jtag_tck = 1'b1;
            #60;
        end
        nRST = 1'b0;
        jtag_tck = 1'b0;
        jtag_shift = 1'b0;
        jtag_sel = 1'b0;
        jtag_tdi = 1'b0;
        repeat (5) @(negedge CLK);
        nRST = 1'b1;
        repeat (5) @(negedge CLK);
        check("rst2_rdy", {63'h0, pipe.to_enq__RDY}, 64'h1);
        check("rst2_ena", {63'h0, pipe.from_enq__ENA}, 64'h0);
        check("rst2_counts", {48'h0, overflow_count, rx_count}, 64'h0);
        check("rst2_tdo", {63'h0, jtag_tdo}, 64'h0);
        exp_q.push_back(32'hCAFE_F00D);
        scan({32'hCAFE_F00D, 1'b1}, 1'b1, 1'b0, '0, 1'b0, dout);
        check("rst2_scan", {31'h0, dout}, 64'h0);
        check("rst2_rx", {32'h0, pipe.from_enq_v}, {32'h0, 32'hCAFE_F00D});

        // SEL=0: no capture, shift or update
        enq(32'hC3C3_C3C3);
        scan(33'h0, 1'b0, 1'b0, '0, 1'b0, dout);
        check("sel0_tdo", {31'h0, dout}, {31'h0, 33'h1_FFFF_FFFF});
        check("sel0_rdy", {63'h0, pipe.to_enq__RDY}, 64'h0);
        check("sel0_ovf", {56'h0, overflow_count}, 64'h0);
        check("sel0_v", {32'h0, pipe.from_enq_v}, {32'h0, 32'hCAFE_F00D});
        pop_one();
        check("rx_count_final", {56'h0, rx_count}, 64'h1);
        check("queue_empty", {32'h0, exp_q.size()}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
